// File: rtl/elevator_request_scheduler_if.sv
// Signal bundle between the request scheduler and its neighbours: button levels,
// the controller's move decode, one-hot floor requests and the status outputs.
interface elevator_request_scheduler_if;
  logic [2:0] btn;
  logic       d2;
  logic       d1;
  logic       n;
  logic       u1;
  logic       u2;
  logic       r1;
  logic       r2;
  logic       r3;
  logic [1:0] floor;
  logic [2:0] pending;
  logic       door_open;
  logic       busy;
  logic       fault;

  modport slave (
    input  btn, d2, d1, n, u1, u2,
    output r1, r2, r3, floor, pending, door_open, busy, fault
  );

  modport master (
    output btn, d2, d1, n, u1, u2,
    input  r1, r2, r3, floor, pending, door_open, busy, fault
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler for a 3-floor car: latches button presses, issues one
// single-cycle floor request at a time, then times travel and door dwell.
//
// state   | meaning
// IDLE    | waiting for a pending request; serves the current floor directly
// REQ     | one cycle driving r<target>, sampling the move decode
// TRAVEL  | car moving, timer counts distance*TRAVEL_CYCLES
// DOOR    | door open at the served floor for DOOR_CYCLES
module elevator_request_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  elevator_request_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_TRAVEL, S_DOOR} state_t;

  localparam logic [CNT_W-1:0] L_T1   = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] L_T2   = CNT_W'(2 * TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] L_DOOR = CNT_W'(DOOR_CYCLES);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_floor, w_floor_nxt;
  logic [1:0]       r_tgt, w_tgt_nxt;
  logic             r_dir_up, w_dir_up_nxt;
  logic [2:0]       r_pending, w_pending_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_fault, w_fault_nxt;

  logic [2:0] w_mask;
  logic       w_up_ok, w_dn_ok;
  logic [1:0] w_up_tgt, w_dn_tgt;
  logic [2:0] w_dest;
  logic       w_far;
  logic       w_legal;

  always_comb begin
    w_mask = 3'b000;
    case (r_floor)
      2'd1:    w_mask = 3'b001;
      2'd2:    w_mask = 3'b010;
      2'd3:    w_mask = 3'b100;
      default: w_mask = 3'b000;
    endcase
  end

  // Nearest pending floor above and below the car
  always_comb begin
    w_up_ok  = 1'b0;
    w_up_tgt = r_floor;
    w_dn_ok  = 1'b0;
    w_dn_tgt = r_floor;
    case (r_floor)
      2'd1: begin
        if (r_pending[1]) begin w_up_ok = 1'b1; w_up_tgt = 2'd2; end
        else if (r_pending[2]) begin w_up_ok = 1'b1; w_up_tgt = 2'd3; end
      end
      2'd2: begin
        if (r_pending[2]) begin w_up_ok = 1'b1; w_up_tgt = 2'd3; end
        if (r_pending[0]) begin w_dn_ok = 1'b1; w_dn_tgt = 2'd1; end
      end
      2'd3: begin
        if (r_pending[1]) begin w_dn_ok = 1'b1; w_dn_tgt = 2'd2; end
        else if (r_pending[0]) begin w_dn_ok = 1'b1; w_dn_tgt = 2'd1; end
      end
      default: ;
    endcase
  end

  // Destination floor implied by the controller's move decode
  always_comb begin
    w_dest = {1'b0, r_floor};
    w_far  = 1'b0;
    if (bus.d2) begin
      w_dest = w_dest - 3'd2;
      w_far  = 1'b1;
    end else if (bus.d1) begin
      w_dest = w_dest - 3'd1;
    end else if (bus.u1) begin
      w_dest = w_dest + 3'd1;
    end else if (bus.u2) begin
      w_dest = w_dest + 3'd2;
      w_far  = 1'b1;
    end
    w_legal = $onehot({bus.d2, bus.d1, bus.u1, bus.u2}) && !bus.n &&
              (w_dest != 3'd0) && (w_dest <= 3'd3);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_tgt_nxt     = r_tgt;
    w_dir_up_nxt  = r_dir_up;
    w_timer_nxt   = r_timer;
    w_fault_nxt   = r_fault;
    w_pending_nxt = r_pending | (bus.btn & ~((r_state == S_DOOR) ? w_mask : 3'b000));
    case (r_state)
      S_IDLE: begin
        if ((r_pending & w_mask) != 3'b000) begin
          w_pending_nxt = w_pending_nxt & ~w_mask;
          w_timer_nxt   = L_DOOR;
          w_state_nxt   = S_DOOR;
        end else if (r_pending != 3'b000) begin
          if (r_dir_up) begin
            if (w_up_ok) w_tgt_nxt = w_up_tgt;
            else begin
              w_dir_up_nxt = 1'b0;
              w_tgt_nxt    = w_dn_tgt;
            end
          end else begin
            if (w_dn_ok) w_tgt_nxt = w_dn_tgt;
            else begin
              w_dir_up_nxt = 1'b1;
              w_tgt_nxt    = w_up_tgt;
            end
          end
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_legal) begin
          w_floor_nxt = w_dest[1:0];
          w_timer_nxt = w_far ? L_T2 : L_T1;
          w_state_nxt = S_TRAVEL;
        end else begin
          // Target bit is left pending so the next IDLE pass retries it
          w_fault_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_TRAVEL: begin
        w_timer_nxt = r_timer - 1'b1;
        if (r_timer == CNT_W'(1)) begin
          w_pending_nxt = w_pending_nxt & ~w_mask;
          w_timer_nxt   = L_DOOR;
          w_state_nxt   = S_DOOR;
        end
      end
      S_DOOR: begin
        w_timer_nxt = r_timer - 1'b1;
        if (r_timer == CNT_W'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_floor   <= 2'd1;
      r_tgt     <= 2'd1;
      r_dir_up  <= 1'b1;
      r_pending <= 3'b000;
      r_timer   <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_floor   <= w_floor_nxt;
      r_tgt     <= w_tgt_nxt;
      r_dir_up  <= w_dir_up_nxt;
      r_pending <= w_pending_nxt;
      r_timer   <= w_timer_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign bus.r1        = (r_state == S_REQ) && (r_tgt == 2'd1);
  assign bus.r2        = (r_state == S_REQ) && (r_tgt == 2'd2);
  assign bus.r3        = (r_state == S_REQ) && (r_tgt == 2'd3);
  assign bus.floor     = r_floor;
  assign bus.pending   = r_pending;
  assign bus.door_open = (r_state == S_DOOR);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the elevator request scheduler; the bench plays the
// downstream controller by driving the move decode around each request.
module tb_elevator_request_scheduler;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [2:0] r_vec;

  elevator_request_scheduler_if bus();

  elevator_request_scheduler #(
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DOOR),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign r_vec = {bus.r3, bus.r2, bus.r1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(string tag, logic [1:0] obs, logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(string tag, logic [2:0] obs, logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_moves();
    bus.d2 = 1'b0;
    bus.d1 = 1'b0;
    bus.n  = 1'b0;
    bus.u1 = 1'b0;
    bus.u2 = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.btn = 3'b000;
    clear_moves();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called one tick after REQ: travel of 'cyc' cycles, then DOOR cycles of dwell
  task automatic serve_wait(string tag, int cyc, logic [1:0] fl, logic [2:0] pend);
    repeat (cyc - 1) tick();
    chk1({tag, "_door_before"}, bus.door_open, 1'b0);
    chk1({tag, "_busy_travel"}, bus.busy, 1'b1);
    tick();
    chk1({tag, "_door_rise"}, bus.door_open, 1'b1);
    chk2({tag, "_floor"}, bus.floor, fl);
    chk3({tag, "_pending"}, bus.pending, pend);
    repeat (DOOR - 1) tick();
    chk1({tag, "_door_last"}, bus.door_open, 1'b1);
    tick();
    chk1({tag, "_door_fall"}, bus.door_open, 1'b0);
    chk1({tag, "_busy_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    bus.btn = 3'b000;
    clear_moves();
    repeat (2) @(posedge clk);
    #1;
    chk2("rst_floor", bus.floor, 2'd1);
    chk3("rst_pending", bus.pending, 3'b000);
    chk3("rst_req", r_vec, 3'b000);
    chk1("rst_door", bus.door_open, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_fault", bus.fault, 1'b0);
    reset = 1'b0;

    // 1 -> 2 with u1
    bus.btn = 3'b010;
    tick();
    chk3("t1_pending", bus.pending, 3'b010);
    chk1("t1_idle", bus.busy, 1'b0);
    bus.btn = 3'b000;
    bus.u1  = 1'b1;
    tick();
    chk3("t1_req", r_vec, 3'b010);
    chk1("t1_busy", bus.busy, 1'b1);
    tick();
    bus.u1 = 1'b0;
    chk2("t1_floor", bus.floor, 2'd2);
    chk3("t1_req_gone", r_vec, 3'b000);
    serve_wait("t1", TRAVEL, 2'd2, 3'b000);

    // 1 -> 3 with u2, double travel time
    do_reset();
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    bus.u2  = 1'b1;
    tick();
    chk3("t2_req", r_vec, 3'b100);
    tick();
    bus.u2 = 1'b0;
    chk2("t2_floor", bus.floor, 2'd3);
    serve_wait("t2", 2 * TRAVEL, 2'd3, 3'b000);

    // SCAN: park at 2 heading up, then pending 101 -> 3 first, then 1
    do_reset();
    bus.btn = 3'b010;
    tick();
    bus.btn = 3'b000;
    bus.u1  = 1'b1;
    tick();
    tick();
    bus.u1 = 1'b0;
    serve_wait("t3a", TRAVEL, 2'd2, 3'b000);
    bus.btn = 3'b101;
    tick();
    chk3("t3_pending", bus.pending, 3'b101);
    bus.btn = 3'b000;
    bus.u1  = 1'b1;
    tick();
    chk3("t3_req_up", r_vec, 3'b100);
    tick();
    bus.u1 = 1'b0;
    chk2("t3_floor3", bus.floor, 2'd3);
    serve_wait("t3b", TRAVEL, 2'd3, 3'b001);
    bus.d2 = 1'b1;
    tick();
    chk3("t3_req_down", r_vec, 3'b001);
    tick();
    bus.d2 = 1'b0;
    chk2("t3_floor1", bus.floor, 2'd1);
    serve_wait("t3c", 2 * TRAVEL, 2'd1, 3'b000);

    // Button at the current floor: door opens without a request
    bus.btn = 3'b001;
    tick();
    chk3("t4_pending_set", bus.pending, 3'b001);
    chk1("t4_door_pre", bus.door_open, 1'b0);
    tick();
    chk1("t4_door", bus.door_open, 1'b1);
    chk3("t4_pending_clr", bus.pending, 3'b000);
    chk3("t4_no_req", r_vec, 3'b000);
    repeat (DOOR - 1) begin
      tick();
      chk1("t4_door_held", bus.door_open, 1'b1);
      chk3("t4_pending_held", bus.pending, 3'b000);
      chk3("t4_no_req_held", r_vec, 3'b000);
    end
    tick();
    chk1("t4_door_fall", bus.door_open, 1'b0);
    chk3("t4_pending_end", bus.pending, 3'b000);
    bus.btn = 3'b000;

    // Illegal decode: n=1 during REQ, then retry with u1
    bus.btn = 3'b010;
    tick();
    bus.btn = 3'b000;
    bus.n   = 1'b1;
    tick();
    chk3("t5_req", r_vec, 3'b010);
    tick();
    bus.n = 1'b0;
    chk1("t5_fault", bus.fault, 1'b1);
    chk2("t5_floor", bus.floor, 2'd1);
    chk3("t5_pending", bus.pending, 3'b010);
    chk1("t5_idle", bus.busy, 1'b0);
    bus.u1 = 1'b1;
    tick();
    chk3("t5_req_retry", r_vec, 3'b010);
    tick();
    bus.u1 = 1'b0;
    chk2("t5_floor2", bus.floor, 2'd2);
    chk1("t5_fault_sticky", bus.fault, 1'b1);

    // Reset mid-TRAVEL with pending 110 clears everything before the next edge
    do_reset();
    bus.btn = 3'b010;
    tick();
    bus.btn = 3'b000;
    bus.u1  = 1'b1;
    tick();
    tick();
    bus.u1  = 1'b0;
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    chk3("t6_pending", bus.pending, 3'b110);
    chk1("t6_busy", bus.busy, 1'b1);
    chk2("t6_floor", bus.floor, 2'd2);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk2("t6_floor_rst", bus.floor, 2'd1);
    chk3("t6_pending_rst", bus.pending, 3'b000);
    chk1("t6_busy_rst", bus.busy, 1'b0);
    chk1("t6_door_rst", bus.door_open, 1'b0);
    chk3("t6_req_rst", r_vec, 3'b000);
    chk1("t6_fault_rst", bus.fault, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Upstream request stage for the 3-floor elevator move controller. Latches hall/car button presses into a pending set and picks one target floor at a time using a SCAN (keep-direction) policy. Issues that target as a single-cycle one-hot r1/r2/r3 request to the controller, and reads back the controller's d2/d1/n/u1/u2 move decode to track the car floor. Times travel and door dwell, then clears the served request.

Parameters:
TRAVEL_CYCLES, 8, cycles of travel per floor moved (>=1)
DOOR_CYCLES, 4, cycles door_open is held at a served floor (>=1)
CNT_W, 8, timer width; must hold 2*TRAVEL_CYCLES and DOOR_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
btn  input  3  button level per floor; bit0=floor1, bit1=floor2, bit2=floor3
d2, d1, n, u1, u2  input  1 each  move decode from the downstream controller
r1, r2, r3  output  1 each  one-hot floor request to the controller; all 0 when not issuing
floor  output  2  tracked car floor, encoded 1..3
pending  output  3  outstanding requests, same bit order as btn
door_open  output  1  high during door dwell
busy  output  1  high in any state other than IDLE
fault  output  1  sticky; move decode inconsistent with the issued request

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, floor=1, dir=UP, pending=0, timer=0, r1/r2/r3=0, door_open=0, busy=0, fault=0. The downstream controller also powers up at floor 1; the system asserts reset before the first request.
- Pending capture: on each clock, pending |= btn, except the bit for the current floor is not set while in DOOR. A set bit is cleared only at DOOR entry, and the clear wins over a same-cycle btn on that floor.
- State IDLE:
  - If pending has the current-floor bit set: clear it, load timer=DOOR_CYCLES, go to DOOR. No request is issued.
  - Else, if pending is nonzero, select a target.
    - dir=UP: target is the nearest pending floor above the current floor. If none exists, set dir=DOWN and take the nearest pending floor below.
    - dir=DOWN: mirror of the UP rule.
  - Register the target and go to REQ.
  - Else stay in IDLE.
- State REQ (exactly 1 cycle): drive r<target>=1 and the other two requests 0. Sample the move inputs in the same cycle (the controller is combinational Mealy).
  - Legal decode: exactly one of d2/d1/u1/u2 is high and n=0. Then floor <= floor +/- 1 or 2 accordingly, timer <= distance*TRAVEL_CYCLES, go to TRAVEL.
  - Illegal decode (n=1, none high, several high, or result outside 1..3): floor is unchanged, fault <= 1, go to IDLE. The target bit stays pending, so it is retried next pass.
- State TRAVEL: decrement timer each cycle. When timer==1, clear the pending bit of floor, load timer=DOOR_CYCLES, go to DOOR.
- State DOOR: door_open=1, decrement timer each cycle. When timer==1, go to IDLE.
- door_open is 1 for exactly DOOR_CYCLES cycles per service.
- busy = (state != IDLE).
- Requests r1/r2/r3 are high for only the single REQ cycle, so the controller advances once per request.
- fault clears only on reset.
- Reset mid-operation (any state) returns everything to reset values immediately, including in-flight pending bits.

Test Plan:
- Reset, then btn=3'b010 for 1 cycle -> REQ is 2 cycles later with r2=1. Drive u1=1 -> floor=2; door_open rises 8 cycles after REQ, lasts 4 cycles; pending=0; busy then drops.
- At floor 1, btn=3'b100 -> r3=1, u2 response -> travel lasts 16 cycles, then floor=3.
- SCAN order: at floor 2 with dir=UP and pending=3'b101 -> floor 3 is served first, then dir=DOWN and floor 1 is served; r3 then r1 issued in that order.
- btn=3'b001 pressed while idle at floor 1 -> no r-pulse, door_open high 4 cycles, pending bit cleared. Same button held during DOOR -> does not re-set the bit.
- During REQ with r2 issued, drive n=1 -> fault=1, floor unchanged, pending[1] still 1, r2 reissued on the next pass.
- Assert reset mid-TRAVEL with pending=3'b110 -> floor=1, pending=0, all outputs 0 asynchronously (before the next clock edge).
